mem_bus_arbiter: RTL and testbench

- Shares the single 16-bit-address / 8-bit-data memory bus between the CPU6 core and one DMA requester, e.g. a disk or console controller.
- The CPU has fixed priority. A starvation counter forces a DMA grant after a bounded wait.
- DMA holds the bus for bounded bursts.
- Sits between CPU6/DMA and the memory/IO decode. It owns mem_we and the memory address mux.

---
 rtl/mem_bus_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares the 16-bit-address / 8-bit-data memory bus between the CPU6 core
//   and a single DMA requester. The CPU has fixed priority. A starvation
//   counter forces a DMA grant after DMA_MAX_WAIT denied cycles. DMA bursts
//   are cut off after BURST_MAX transfers. The arbiter owns the memory
//   address/data mux and mem_we.
//
// Ports
//   clock, reset                   rising-edge clock, async active-low reset
//   cpu_req/we/addr/wdata          CPU transfer request
//   cpu_grant                      CPU owns the bus (registered)
//   cpu_rdata, cpu_rvalid          CPU read return (rvalid is a 1-cycle pulse)
//   dma_req/we/addr/wdata/last     DMA transfer request, last marks burst end
//   dma_grant                      DMA owns the bus (registered)
//   dma_rdata, dma_rvalid          DMA read return (rvalid is a 1-cycle pulse)
//   mem_addr, mem_wdata, mem_we    bus outputs, combinational from the owner
//   mem_rdata                      bus read data, valid in the issue cycle

module mem_bus_arbiter #(
    parameter int unsigned DMA_MAX_WAIT = 8,   // 1..255
    parameter int unsigned BURST_MAX    = 16   // 1..255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_grant,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_rvalid,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [15:0] dma_addr,
    input  logic [7:0]  dma_wdata,
    input  logic        dma_last,
    output logic        dma_grant,
    output logic [7:0]  dma_rdata,
    output logic        dma_rvalid,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    input  logic [7:0]  mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CPU,
        ST_DMA
    } state_t;

    state_t     state, next_state;
    logic [7:0] wait_cnt;
    logic [7:0] burst_cnt;

    logic cpu_issue, dma_issue;
    logic starve;
    logic burst_end;
    logic dma_release;
    logic dma_entry;

    assign cpu_issue = (state == ST_CPU) && cpu_req;
    assign dma_issue = (state == ST_DMA) && dma_req;
    assign starve    = (wait_cnt == 8'(DMA_MAX_WAIT));
    // The transfer issuing now is the BURST_MAX-th of this grant.
    assign burst_end = (burst_cnt == 8'(BURST_MAX - 1));

    assign dma_release = !dma_req || (dma_issue && (dma_last || burst_end));
    // A release that lands back in DMA is a fresh burst, so it counts as entry.
    assign dma_entry   = (next_state == ST_DMA) && ((state != ST_DMA) || dma_release);

    assign cpu_grant = (state == ST_CPU);
    assign dma_grant = (state == ST_DMA);

    // NOTE: every output of a combinational block gets a default before the
    // case, so no path can leave it unassigned and infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (cpu_req && !starve) next_state = ST_CPU;
                else if (dma_req)       next_state = ST_DMA;
            end
            ST_CPU: begin
                if (dma_req && starve) next_state = ST_DMA;
                else if (cpu_req)      next_state = ST_CPU;
                else if (dma_req)      next_state = ST_DMA;
                else                   next_state = ST_IDLE;
            end
            ST_DMA: begin
                if (dma_release) begin
                    if (cpu_req)                  next_state = ST_CPU;
                    else if (dma_req && !dma_last) next_state = ST_DMA;
                    else                          next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_addr  = 16'h0000;
        mem_wdata = 8'h00;
        mem_we    = 1'b0;
        case (state)
            ST_CPU: begin
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                mem_we    = cpu_req && cpu_we;
            end
            ST_DMA: begin
                mem_addr  = dma_addr;
                mem_wdata = dma_wdata;
                mem_we    = dma_req && dma_we;
            end
            default: ;
        endcase
    end

    // NOTE: state and counters use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            wait_cnt  <= 8'd0;
            burst_cnt <= 8'd0;
        end else begin
            state <= next_state;

            if (dma_entry || !dma_req)
                wait_cnt <= 8'd0;
            else if (state != ST_DMA && !starve)
                wait_cnt <= wait_cnt + 8'd1;

            if (dma_entry)
                burst_cnt <= 8'd0;
            else if (dma_issue)
                burst_cnt <= burst_cnt + 8'd1;
        end
    end

    // Read data is captured on the issue edge, so a read issued in a handover
    // cycle still returns to its issuer after the grant has moved on.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cpu_rdata  <= 8'h00;
            cpu_rvalid <= 1'b0;
            dma_rdata  <= 8'h00;
            dma_rvalid <= 1'b0;
        end else begin
            cpu_rvalid <= cpu_issue && !cpu_we;
            dma_rvalid <= dma_issue && !dma_we;
            if (cpu_issue && !cpu_we) cpu_rdata <= mem_rdata;
            if (dma_issue && !dma_we) dma_rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
//   Scoreboard bench for mem_bus_arbiter. Stimulus pushes the expected bus
//   transfers and read returns into queues; a monitor pops and compares
//   whenever the DUT issues a transfer or pulses an rvalid. Cycle-exact grant
//   timing is checked directly by the stimulus.

module tb_mem_bus_arbiter;

    typedef struct packed {
        logic        is_dma;
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } bus_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        cpu_grant, cpu_rvalid;
    logic [7:0]  cpu_rdata;
    logic        dma_req = 1'b0, dma_we = 1'b0, dma_last = 1'b0;
    logic [15:0] dma_addr = '0;
    logic [7:0]  dma_wdata = '0;
    logic        dma_grant, dma_rvalid;
    logic [7:0]  dma_rdata;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata;

    int checks = 0;
    int errors = 0;

    bus_t       bus_q[$];
    logic [7:0] cpu_rq[$];
    logic [7:0] dma_rq[$];

    mem_bus_arbiter #(.DMA_MAX_WAIT(8), .BURST_MAX(16)) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_grant(cpu_grant), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_last(dma_last), .dma_grant(dma_grant), .dma_rdata(dma_rdata),
        .dma_rvalid(dma_rvalid),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    // Memory model: 0x1234 holds 0x5A, every other address reads addr[7:0]^0x3C.
    assign mem_rdata = (mem_addr == 16'h1234) ? 8'h5A : (mem_addr[7:0] ^ 8'h3C);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bus_t mk(input logic is_dma, input logic we,
                                input logic [15:0] addr, input logic [7:0] wdata);
        bus_t b;
        b.is_dma = is_dma;
        b.we     = we;
        b.addr   = addr;
        b.wdata  = wdata;
        return b;
    endfunction

    // Owner per cycle of the 20-write burst scenario: {cpu_grant, dma_grant}.
    // DMA c1..c16 (16 writes), CPU c17..c25 (wait_cnt 0..8), DMA c26..c30,
    // CPU c31..c32, IDLE otherwise.
    function automatic logic [1:0] burst_owner(input int c);
        if (c >= 1 && c <= 16)  return 2'b01;
        if (c >= 17 && c <= 25) return 2'b10;
        if (c >= 26 && c <= 30) return 2'b01;
        if (c >= 31 && c <= 32) return 2'b10;
        return 2'b00;
    endfunction

    // Monitor: compares every issued transfer and every read return.
    bus_t mon_act, mon_exp;
    always @(negedge clock) begin
        if (reset) begin
            check("grant_exclusive", 32'(cpu_grant && dma_grant), 32'd0);
            if ((cpu_grant && cpu_req) || (dma_grant && dma_req)) begin
                mon_act = mk(dma_grant, mem_we, mem_addr, mem_we ? mem_wdata : 8'h00);
                if (bus_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL bus_unexpected: got 0x%0h, expected no transfer", mon_act);
                end else begin
                    mon_exp = bus_q.pop_front();
                    check("bus_txn", {6'd0, mon_act}, {6'd0, mon_exp});
                end
            end
            if (cpu_rvalid) begin
                if (cpu_rq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL cpu_rvalid_unexpected: got 0x%0h, expected no return", cpu_rdata);
                end else
                    check("cpu_rdata", 32'(cpu_rdata), 32'(cpu_rq.pop_front()));
            end
            if (dma_rvalid) begin
                if (dma_rq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dma_rvalid_unexpected: got 0x%0h, expected no return", dma_rdata);
                end else
                    check("dma_rdata", 32'(dma_rdata), 32'(dma_rq.pop_front()));
            end
        end
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    int n_dma;

    initial begin
        // ---------------- reset state ----------------
        #2;
        check("rst_flags", 32'({cpu_grant, dma_grant, mem_we, cpu_rvalid, dma_rvalid}), 32'd0);
        check("rst_rdata", 32'({cpu_rdata, dma_rdata}), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        next_cycle();
        next_cycle();
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            check("idle_bus", 32'({cpu_grant, dma_grant, mem_we, mem_addr}), 32'd0);
            next_cycle();
        end

        // ---------------- CPU read 0x1234 from IDLE ----------------
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234; cpu_wdata = 8'h00;
        bus_q.push_back(mk(1'b0, 1'b0, 16'h1234, 8'h00));
        cpu_rq.push_back(8'h5A);
        @(negedge clock);
        check("rd_grant_N", 32'(cpu_grant), 32'd0);
        next_cycle();
        @(negedge clock);
        check("rd_grant_N1", 32'({cpu_grant, dma_grant}), 32'b10);
        check("rd_addr_N1", 32'(mem_addr), 32'h1234);
        check("rd_we_N1", 32'(mem_we), 32'd0);
        check("rd_rvalid_N1", 32'(cpu_rvalid), 32'd0);
        next_cycle();
        cpu_req = 1'b0;
        @(negedge clock);
        check("rd_rvalid_N2", 32'(cpu_rvalid), 32'd1);
        check("rd_rdata_N2", 32'(cpu_rdata), 32'h5A);
        check("rd_dma_quiet", 32'({dma_rvalid, dma_rdata}), 32'd0);
        next_cycle();
        @(negedge clock);
        check("rd_pulse_end", 32'({cpu_rvalid, cpu_grant}), 32'd0);
        check("rd_rdata_hold", 32'(cpu_rdata), 32'h5A);
        next_cycle();

        // ---------------- starvation: CPU continuous, DMA from cycle 0 ----------------
        // CPU wins c1..c8 while wait_cnt climbs 1..8; DMA wins c9; CPU again c10.
        for (int i = 0; i < 8; i++) bus_q.push_back(mk(1'b0, 1'b1, 16'h0100, 8'h11));
        bus_q.push_back(mk(1'b1, 1'b1, 16'h2000, 8'hA5));
        bus_q.push_back(mk(1'b0, 1'b1, 16'h0100, 8'h11));
        for (int c = 0; c <= 12; c++) begin
            cpu_req  = (c <= 10);
            cpu_we   = 1'b1; cpu_addr = 16'h0100; cpu_wdata = 8'h11;
            dma_req  = (c <= 9);
            dma_we   = 1'b1; dma_addr = 16'h2000; dma_wdata = 8'hA5; dma_last = 1'b1;
            @(negedge clock);
            if (c == 0 || c == 12)
                check("stv_idle", 32'({cpu_grant, dma_grant}), 32'b00);
            else if (c == 9) begin
                check("stv_dma_grant", 32'({cpu_grant, dma_grant}), 32'b01);
                check("stv_dma_bus", 32'({mem_we, mem_addr, mem_wdata}), {7'd0, 1'b1, 16'h2000, 8'hA5});
            end else
                check("stv_cpu_grant", 32'({cpu_grant, dma_grant}), 32'b10);
            next_cycle();
        end
        dma_last = 1'b0;

        // ---------------- 20-write DMA burst vs BURST_MAX=16, CPU contending ----------------
        for (int i = 0; i < 16; i++) bus_q.push_back(mk(1'b1, 1'b1, 16'h3000 + 16'(i), 8'(i)));
        for (int i = 0; i < 9; i++)  bus_q.push_back(mk(1'b0, 1'b1, 16'h0400, 8'h22));
        for (int i = 16; i < 20; i++) bus_q.push_back(mk(1'b1, 1'b1, 16'h3000 + 16'(i), 8'(i)));
        bus_q.push_back(mk(1'b0, 1'b1, 16'h0400, 8'h22));
        n_dma = 0;
        for (int c = 0; c <= 33; c++) begin
            cpu_req = (c >= 1 && c <= 31);
            cpu_we = 1'b1; cpu_addr = 16'h0400; cpu_wdata = 8'h22;
            dma_req = (n_dma < 20);
            dma_we = 1'b1; dma_addr = 16'h3000 + 16'(n_dma); dma_wdata = 8'(n_dma);
            @(negedge clock);
            check("burst_owner", 32'({cpu_grant, dma_grant}), 32'(burst_owner(c)));
            if (dma_grant && dma_req) n_dma++;
            next_cycle();
        end
        check("burst_count", 32'(n_dma), 32'd20);
        cpu_req = 1'b0;
        dma_req = 1'b0;

        // ---------------- dma_last on 3rd transfer (a read), CPU idle ----------------
        bus_q.push_back(mk(1'b1, 1'b1, 16'h4000, 8'h40));
        bus_q.push_back(mk(1'b1, 1'b1, 16'h4001, 8'h41));
        bus_q.push_back(mk(1'b1, 1'b0, 16'h4002, 8'h00));
        dma_rq.push_back(8'h3E);  // 0x02 ^ 0x3C
        n_dma = 0;
        for (int c = 0; c <= 5; c++) begin
            dma_req   = (n_dma < 3);
            dma_last  = (n_dma == 2);
            dma_we    = (n_dma != 2);
            dma_addr  = 16'h4000 + 16'(n_dma);
            dma_wdata = (n_dma == 2) ? 8'h00 : 8'h40 + 8'(n_dma);
            @(negedge clock);
            if (c >= 1 && c <= 3)
                check("last_dma_grant", 32'({cpu_grant, dma_grant}), 32'b01);
            else
                check("last_idle", 32'({cpu_grant, dma_grant}), 32'b00);
            if (c == 4) check("last_rvalid", 32'({dma_rvalid, dma_rdata}), {23'd0, 1'b1, 8'h3E});
            if (c == 5) check("last_rvalid_end", 32'(dma_rvalid), 32'd0);
            if (dma_grant && dma_req) n_dma++;
            next_cycle();
        end
        dma_last = 1'b0;
        dma_req  = 1'b0;

        // ---------------- reset asserted in the issue cycle of a DMA read ----------------
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h5000; dma_wdata = 8'h00;
        bus_q.push_back(mk(1'b1, 1'b0, 16'h5000, 8'h00));
        @(negedge clock);
        check("mrst_pre_idle", 32'({cpu_grant, dma_grant}), 32'b00);
        next_cycle();
        @(negedge clock);
        check("mrst_issue", 32'({dma_grant, mem_we, mem_addr}), {14'd0, 1'b1, 1'b0, 16'h5000});
        #2;
        reset = 1'b0;
        #1;
        check("mrst_async", 32'({cpu_grant, dma_grant, mem_we, mem_addr}), 32'd0);
        check("mrst_rdata", 32'({dma_rvalid, dma_rdata}), 32'd0);
        next_cycle();
        dma_req = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("mrst_after", 32'({cpu_grant, dma_grant, dma_rvalid, cpu_rvalid}), 32'd0);
            next_cycle();
        end

        check("bus_q_drained", 32'(bus_q.size()), 32'd0);
        check("cpu_rq_drained", 32'(cpu_rq.size()), 32'd0);
        check("dma_rq_drained", 32'(dma_rq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
